awgn_output_stage: RTL and testbench

//  Final Box-Muller stage, directly downstream of sqrt. Takes f = sqrt(-2 ln u0)
//  (u17.13) and the quadrature pair g0 = sin(2*pi*u1), g1 = cos(2*pi*u1) (s16.15).

---
 rtl/awgn_pkg.sv | 18 +
 rtl/awgn_mul_round.sv | 37 +++
 rtl/awgn_output_stage.sv | 124 ++++++++++++
 tb/tb_awgn_output_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
// Shared constants and FSM encoding for the AWGN Box-Muller pipeline stages.
package awgn_pkg;

  localparam int unsigned F_W   = 17;
  localparam int unsigned G_W   = 16;
  localparam int unsigned X_W   = 16;
  localparam int unsigned SHIFT = 17;
  localparam int unsigned CNT_W = 32;
  // {1'b0,f} * g product width
  localparam int unsigned P_W   = F_W + 1 + G_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SEND0 = 2'd1,
    ST_SEND1 = 2'd2
  } state_e;

endpackage

// File: rtl/awgn_mul_round.sv
// One Box-Muller branch: f*g product (feeds the S1 register) and the
// round-half-up / saturate of the registered product back to s16.11.
module awgn_mul_round
  import awgn_pkg::*;
(
  input  logic [F_W-1:0] f_i,
  input  logic [G_W-1:0] g_i,
  output logic [P_W-1:0] p_o,
  input  logic [P_W-1:0] p_i,
  output logic [X_W-1:0] x_o
);

  localparam logic [P_W-1:0] HALF = {{(P_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic signed [P_W-1:0] f_ext;
  logic signed [P_W-1:0] g_ext;
  logic        [P_W-1:0] biased;
  logic signed [P_W-1:0] shifted;
  logic        [P_W-X_W:0] upper;

  assign f_ext = {{(P_W-F_W){1'b0}}, f_i};
  assign g_ext = {{(P_W-G_W){g_i[G_W-1]}}, g_i};
  assign p_o   = f_ext * g_ext;

  assign biased  = p_i + HALF;
  assign shifted = $signed(biased) >>> SHIFT;
  assign upper   = shifted[P_W-1:X_W-1];

  // In range only when every bit above the output sign bit matches it.
  always_comb begin
    x_o = shifted[X_W-1:0];
    if (!((&upper) || (~|upper))) begin
      x_o = shifted[P_W-1] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/awgn_output_stage.sv
// Box-Muller output stage: f*sin / f*cos, rounded to s16.11, serialised
// as x0 then x1 on a valid/ready stream with a delivered-sample counter.
module awgn_output_stage
  import awgn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F_W-1:0]   f,
  input  logic [G_W-1:0]   g0,
  input  logic [G_W-1:0]   g1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   out_data,
  output logic             out_idx,
  output logic [CNT_W-1:0] sample_cnt
);

  logic             s1_valid_q;
  logic [P_W-1:0]   p0_q, p1_q;
  logic [P_W-1:0]   p0_d, p1_d;
  logic [X_W-1:0]   x0_d, x1_d;
  logic [X_W-1:0]   x1_q;
  state_e           state_q;
  logic             out_valid_q;
  logic [X_W-1:0]   out_data_q;
  logic             out_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pair_load;
  logic             accept;

  awgn_mul_round u_branch0 (
    .f_i (f),
    .g_i (g0),
    .p_o (p0_d),
    .p_i (p0_q),
    .x_o (x0_d)
  );

  awgn_mul_round u_branch1 (
    .f_i (f),
    .g_i (g1),
    .p_o (p1_d),
    .p_i (p1_q),
    .x_o (x1_d)
  );

  always_comb begin
    pair_load = s1_valid_q &&
                ((state_q == ST_EMPTY) || ((state_q == ST_SEND1) && out_ready));
    in_ready  = !s1_valid_q || pair_load;
    accept    = in_valid && in_ready;
  end

  // out_data holds x0 directly on load; x1 waits in x1_q until SEND1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      x1_q        <= '0;
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        p0_q       <= p0_d;
        p1_q       <= p1_d;
      end else if (pair_load) begin
        s1_valid_q <= 1'b0;
      end

      if (out_valid_q && out_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_EMPTY: begin
          if (pair_load) begin
            state_q     <= ST_SEND0;
            out_valid_q <= 1'b1;
            out_data_q  <= x0_d;
            out_idx_q   <= 1'b0;
            x1_q        <= x1_d;
          end
        end
        ST_SEND0: begin
          if (out_ready) begin
            state_q    <= ST_SEND1;
            out_data_q <= x1_q;
            out_idx_q  <= 1'b1;
          end
        end
        ST_SEND1: begin
          if (out_ready) begin
            if (pair_load) begin
              state_q    <= ST_SEND0;
              out_data_q <= x0_d;
              out_idx_q  <= 1'b0;
              x1_q       <= x1_d;
            end else begin
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_awgn_output_stage.sv
// Directed bench for awgn_output_stage: arithmetic, latency, backpressure,
// streaming throughput and mid-operation reset.
module tb_awgn_output_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] f;
  logic [15:0] g0;
  logic [15:0] g1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_idx;
  logic [31:0] sample_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  longint      cyc = 0;
  int unsigned n_cons = 0;
  longint      first_cons = -1;
  longint      last_cons = -1;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  awgn_output_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .f          (f),
    .g0         (g0),
    .g1         (g1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .sample_cnt (sample_cnt)
  );

  // Reference: floor((f*g + 2^16) / 2^17) with saturation to s16.
  function automatic logic [15:0] model(input logic [16:0] fv, input logic [15:0] gv);
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] rb;
    p = longint'(fv) * longint'($signed(gv));
    q = p + 65536;
    if (q >= 0) r = q / 131072;
    else        r = -((-q + 131071) / 131072);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    rb = 64'(r);
    return rb[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle of stream bookkeeping: score the sample consumed at the coming
  // edge and queue the expectations for an input accepted at that edge.
  task automatic step(output bit acc);
    logic [16:0] e;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_sample", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", 32'(out_data), 32'(e[15:0]));
        chk("stream_idx", 32'(out_idx), 32'(e[16]));
      end
      n_cons++;
      if (first_cons < 0) first_cons = cyc;
      last_cons = cyc;
    end
    if (acc) begin
      exp_q.push_back({1'b0, model(f, g0)});
      exp_q.push_back({1'b1, model(f, g1)});
    end
    tick();
  endtask

  task automatic direct_pair(input logic [16:0] fv, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] e0, input logic [15:0] e1);
    logic [31:0] c0;
    out_ready = 1'b1;
    f = fv; g0 = a; g1 = b;
    in_valid = 1'b1;
    c0 = sample_cnt;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("no_output_one_edge", 32'(out_valid), 32'd0);
    tick();
    chk("x0_valid", 32'(out_valid), 32'd1);
    chk("x0_data", 32'(out_data), 32'(e0));
    chk("x0_idx", 32'(out_idx), 32'd0);
    tick();
    chk("x1_valid", 32'(out_valid), 32'd1);
    chk("x1_data", 32'(out_data), 32'(e1));
    chk("x1_idx", 32'(out_idx), 32'd1);
    chk("cnt_after_x0", sample_cnt, c0 + 32'd1);
    tick();
    chk("idle_after_pair", 32'(out_valid), 32'd0);
    chk("cnt_after_x1", sample_cnt, c0 + 32'd2);
  endtask

  initial begin
    bit          acc;
    int unsigned k;
    logic [31:0] c0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f = '0; g0 = '0; g1 = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_sample_cnt", sample_cnt, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic, rounding, extreme magnitude
    direct_pair(17'h02000, 16'h4000, 16'hC000, 16'h0400, 16'hFC00);
    chk("cnt_test1", sample_cnt, 32'd2);
    direct_pair(17'h02000, 16'h0008, 16'h0001, 16'h0001, 16'h0000);
    direct_pair(17'h1FFFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);

    // Backpressure: three pairs offered while the consumer stalls
    out_ready = 1'b0;
    n_cons = 0;
    f = 17'h02000; g0 = 16'h1000; g1 = 16'h0800;
    in_valid = 1'b1;
    step(acc);
    chk("bp_accept_a", 32'(acc), 32'd1);
    f = 17'h04000; g0 = 16'hE000; g1 = 16'h2000;
    step(acc);
    chk("bp_accept_b", 32'(acc), 32'd1);
    f = 17'h01000; g0 = 16'h7FFF; g1 = 16'h8001;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_x0", 32'(out_data), 32'h0100);
    repeat (4) begin
      step(acc);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_stable_data", 32'(out_data), 32'h0100);
      chk("bp_stable_idx", 32'(out_idx), 32'd0);
    end
    out_ready = 1'b1;
    k = 0;
    while ((in_valid || exp_q.size() != 0) && k < 20) begin
      step(acc);
      if (acc) in_valid = 1'b0;
      k++;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_delivered", 32'(n_cons), 32'd6);
    chk("bp_cnt", sample_cnt, 32'd12);

    // Random stream at full rate
    n_cons = 0; first_cons = -1; last_cons = -1;
    c0 = sample_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      f  = 17'($urandom_range(0, 17'h1FFFF));
      g0 = 16'($urandom);
      g1 = 16'($urandom);
      in_valid = 1'b1;
      k = 0;
      acc = 1'b0;
      while (!acc && k < 10) begin
        step(acc);
        k++;
      end
      if (!acc) chk("stream_accept_timeout", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      step(acc);
      k++;
    end
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_delivered", 32'(n_cons), 32'd200);
    chk("stream_cnt", sample_cnt - c0, 32'd200);
    chk("stream_rate", 32'(last_cons - first_cons), 32'd199);

    // Reset while SEND0 with S1 full
    out_ready = 1'b0;
    f = 17'h02000; g0 = 16'h4000; g1 = 16'h4000;
    in_valid = 1'b1;
    step(acc);
    step(acc);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_cnt", sample_cnt, 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    repeat (4) begin
      tick();
      chk("post_rst_silent", 32'(out_valid), 32'd0);
    end
    chk("post_rst_cnt", sample_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
